// File: rtl/object_pkg.sv
// Object identifiers shared by the frame decoder blocks.
package object_pkg;

  typedef enum logic [1:0] {
    OBJ_MAP  = 2'd0,
    OBJ_BAR  = 2'd1,
    OBJ_CAR1 = 2'd2,
    OBJ_CAR2 = 2'd3
  } object_id_e;

endpackage

// File: rtl/sram_pkg.sv
// SRAM layout tables for the frame decoder objects and the lane side-channel record.
package sram_pkg;
  import object_pkg::*;

  localparam int N_OBJ  = 4;
  localparam int OBJ_W  = $bits(object_id_e);
  localparam int IDX_W  = 19;
  localparam int ADDR_W = 20;
  localparam int LANE_W = 2;
  localparam int RD_LAT = 2;

  // Indexed by object_id_e: MAP, BAR, CAR1, CAR2.
  localparam logic [ADDR_W-1:0] OBJ_BASE [N_OBJ] = '{20'h00000, 20'h12C00, 20'h14000, 20'h14400};
  localparam logic [IDX_W-1:0]  OBJ_SIZE [N_OBJ] = '{19'd307200, 19'd20480, 19'd1024, 19'd1024};
  localparam logic [LANE_W-1:0] OBJ_SHIFT[N_OBJ] = '{2'd2, 2'd2, 2'd0, 2'd0};

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [OBJ_W-1:0]  obj_id;
    logic              oob;
  } lane_info_t;

  // Low 'shift' bits set: selects the pixel lane inside a packed word.
  function automatic logic [LANE_W-1:0] lane_mask(input logic [LANE_W-1:0] shift);
    return ~({LANE_W{1'b1}} << shift);
  endfunction

endpackage

// File: rtl/sram_lane_delay.sv
// Fixed-latency, never-stalling, valid-tagged shift register for lane info.
module sram_lane_delay
  import sram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push_i,
  input  lane_info_t i_info_i,
  output logic       o_valid_o,
  output lane_info_t o_info_o
);

  logic [DEPTH-1:0] valid_q;
  lane_info_t       info_q [DEPTH];

  // Empty slots carry zero info so the outputs read 0 whenever valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) info_q[i] <= '0;
    end else begin
      valid_q[0] <= i_push_i;
      info_q[0]  <= i_push_i ? i_info_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        info_q[i]  <= info_q[i-1];
      end
    end
  end

  assign o_valid_o = valid_q[DEPTH-1];
  assign o_info_o  = info_q[DEPTH-1];

endmodule

// File: rtl/sram_addr_gen.sv
// Maps (object id, pixel index) to an SRAM word address with backpressure,
// out-of-bounds flagging and a read-latency-aligned lane side channel.
module sram_addr_gen
  import sram_pkg::*;
#(
  parameter int RD_LAT = sram_pkg::RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OBJ_W-1:0]  i_obj_id,
  input  logic [IDX_W-1:0]  i_pixel_index,
  output logic              o_sram_valid,
  input  logic              i_sram_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_oob,
  output logic              o_lane_valid,
  output logic [LANE_W-1:0] o_lane,
  output logic [OBJ_W-1:0]  o_lane_obj_id,
  output logic              o_lane_oob,
  output logic [15:0]       o_oob_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and an offered address holds
  // stable until it transfers.

  logic              id_valid;
  logic [LANE_W-1:0] shift;
  logic [ADDR_W-1:0] addr_d;
  logic [LANE_W-1:0] lane_d;
  logic              oob_d;

  always_comb begin
    id_valid = ({1'b0, i_obj_id} < (OBJ_W + 1)'(N_OBJ));
    shift    = '0;
    addr_d   = '0;
    lane_d   = '0;
    oob_d    = 1'b1;
    if (id_valid) begin
      shift  = OBJ_SHIFT[i_obj_id];
      oob_d  = (i_pixel_index >= OBJ_SIZE[i_obj_id]);
      addr_d = OBJ_BASE[i_obj_id];
      if (!oob_d) begin
        addr_d = OBJ_BASE[i_obj_id] + (ADDR_W'(i_pixel_index) >> shift);
        lane_d = i_pixel_index[LANE_W-1:0] & lane_mask(shift);
      end
    end
  end

  logic              sram_valid_q;
  logic [ADDR_W-1:0] sram_addr_q;
  lane_info_t        info_q;
  logic [15:0]       oob_cnt_q;
  logic              accept;
  logic              sram_hs;

  assign o_req_ready = !sram_valid_q | i_sram_ready;
  assign accept      = i_req_valid & o_req_ready;
  assign sram_hs     = sram_valid_q & i_sram_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sram_valid_q <= 1'b0;
      sram_addr_q  <= '0;
      info_q       <= '0;
    end else if (accept) begin
      sram_valid_q <= 1'b1;
      sram_addr_q  <= addr_d;
      info_q       <= '{lane: lane_d, obj_id: i_obj_id, oob: oob_d};
    end else if (i_sram_ready) begin
      sram_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oob_cnt_q <= '0;
    end else if (sram_hs && info_q.oob && oob_cnt_q != 16'hFFFF) begin
      oob_cnt_q <= oob_cnt_q + 16'd1;
    end
  end

  lane_info_t lane_out;

  sram_lane_delay #(
    .DEPTH(RD_LAT)
  ) u_lane_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push_i (sram_hs),
    .i_info_i (info_q),
    .o_valid_o(o_lane_valid),
    .o_info_o (lane_out)
  );

  assign o_sram_valid  = sram_valid_q;
  assign o_sram_addr   = sram_addr_q;
  assign o_sram_oob    = info_q.oob;
  assign o_lane        = lane_out.lane;
  assign o_lane_obj_id = lane_out.obj_id;
  assign o_lane_oob    = lane_out.oob;
  assign o_oob_count   = oob_cnt_q;

endmodule

// File: doc/sram_addr_gen.md
Name: sram_addr_gen

Overview:
- Parametrised successor to the frame decoder's single-cycle SRAM address encoder.
- Maps (object id, pixel index) to an SRAM word address using per-object base, size and pixel-packing tables.
- Adds valid/ready backpressure, out-of-bounds detection, and a fixed-latency side channel that delivers sub-word lane select to the pixel unpacker in step with SRAM read data.
- Sits between the frame decoder's object arbiter and the SRAM controller.

Parameters:
- N_OBJ, 4, number of objects (table entries in package)
- OBJ_W, 2, object id width; N_OBJ <= 2**OBJ_W
- IDX_W, 19, pixel index width (MAP_H_WIDTH+MAP_V_WIDTH)
- ADDR_W, 20, SRAM word address width
- LANE_W, 2, sub-word lane width (max pixels-per-word = 2**LANE_W)
- RD_LAT, 2, SRAM read latency in cycles from address handshake to data valid; legal range 1..8

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&ready
- i_obj_id  in  OBJ_W  object id
- i_pixel_index  in  IDX_W  pixel index within object
- o_sram_valid  out  1  address valid toward SRAM controller
- i_sram_ready  in  1  SRAM controller accepts address
- o_sram_addr  out  ADDR_W  registered word address
- o_sram_oob  out  1  request was out of bounds
- o_lane_valid  out  1  lane info aligned with SRAM read data
- o_lane  out  LANE_W  pixel lane within returned word
- o_lane_obj_id  out  OBJ_W  object id aligned with data
- o_lane_oob  out  1  OOB flag aligned with data; unpacker outputs transparent pixel
- o_oob_count  out  16  saturating count of OOB requests issued

Behaviour:
- Reset: all outputs 0; delay line cleared; o_req_ready=1 after reset.
- Address computation, combinational, from package tables:
  - shift = OBJ_SHIFT[id]
  - addr = OBJ_BASE[id] + (idx >> shift), computed at ADDR_W bits with idx zero-extended
  - lane = idx & ((1<<shift)-1)
- OOB: asserted if id >= N_OBJ or idx >= OBJ_SIZE[id].
  - OOB with valid id: addr = OBJ_BASE[id], lane = 0.
  - OOB with invalid id: addr = 0, lane = 0.
- Output register stage:
  - o_req_ready = !o_sram_valid | i_sram_ready.
  - On accept: o_sram_addr, o_sram_oob, o_sram_valid=1 and the held lane/obj_id load next edge (latency 1).
  - Otherwise, if i_sram_ready: o_sram_valid clears.
  - Otherwise all registered outputs hold unchanged. While stalled, addr must not change.
- Same-cycle accept and drain: a new request accepted while the current one drains loads new values, o_sram_valid stays 1. Full throughput is one request/cycle.
- Lane delay line:
  - On o_sram_valid & i_sram_ready, push {lane, obj_id, oob} into a shift register of depth RD_LAT.
  - It advances every cycle and does not stall.
  - Outputs appear on o_lane_* exactly RD_LAT cycles after the SRAM handshake edge.
  - o_lane_valid=0 in empty slots.
- o_oob_count increments once per OOB request at its SRAM handshake and saturates at 16'hFFFF.
- Reset mid-operation: pipeline and delay line flush immediately. Requests in flight are lost; no o_lane_valid pulses occur for them after release.

Decomposition:
- sram_pkg holds:
  - OBJ_BASE[N_OBJ] (ADDR_W): MAP 20'h00000, BAR 20'h12C00, CAR1 20'h14000, CAR2 20'h14400
  - OBJ_SIZE[N_OBJ] (IDX_W): 307200, 20480, 1024, 1024
  - OBJ_SHIFT[N_OBJ] (LANE_W): 2, 2, 0, 0
  - a lane_info_t struct {lane, obj_id, oob}
- object_pkg keeps the ObjectID enum.
- One sub-module: sram_lane_delay, a parametrised RD_LAT-deep valid-tagged shift register of lane_info_t.

Test Plan:
1. MAP, idx 7, i_sram_ready=1 -> next cycle o_sram_addr=20'h00001, o_sram_oob=0. RD_LAT=2 cycles later: o_lane_valid=1, o_lane=3.
2. CAR1, idx 5 -> o_sram_addr=20'h14005, o_lane=0. CAR2, idx 1023 -> o_sram_addr=20'h147FF.
3. BAR, idx 20480 -> o_sram_addr=20'h12C00, o_sram_oob=1, later o_lane_oob=1, o_oob_count=1. Repeat with MAP idx 307200 -> count 2.
4. Back-to-back MAP idx 0,4,8, with i_sram_ready low for 3 cycles after the first -> o_sram_addr held at 20'h00000 and o_req_ready=0 during the stall. Then addresses 0x00001 and 0x00002 follow on consecutive cycles; lane outputs stay RD_LAT after each handshake.
5. Stream of 4 requests; assert i_rst_n=0 for one cycle mid-stream -> all outputs 0 immediately, and no o_lane_valid pulse for pre-reset requests.
6. Force 65540 OOB handshakes (or preload via force) -> o_oob_count holds at 16'hFFFF.
